// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter
// Round-robin drain of NUM_CH edge-triggered FIFOs into a single sink.
// Each pop is a one-cycle fifo_read_en pulse. At least two low cycles always
// follow a pulse, so the FIFO's edge detector sees every pop. The popped word
// is held on out_data until the sink takes it.
// Optional build macro FIFO_DRAIN_ARB_PRIO_EN: fixed priority (lowest-index
// non-empty channel wins) replaces round-robin; burst length still applies.
//
// Handshake: out_valid/out_ready follow strict valid/ready rules. A word
// transfers on a rising clock edge where both are high. While out_valid is
// high and out_ready is low, out_data and out_channel do not change.
// out_valid never drops without a transfer, except on reset.
module fifo_drain_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 2,
    parameter int BURST_LEN  = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_CH-1:0]            fifo_read_en,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_channel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PULSE   = 2'd2,
        S_SEND    = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CH_W-1:0]       r_grant;
    logic [7:0]            r_burst_cnt;
    logic [NUM_CH-1:0]     r_read_en;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CH_W-1:0]       r_out_channel;
    logic                  r_out_valid;

    logic [CH_W-1:0]       w_grant_nxt;
    logic [7:0]            w_burst_cnt_nxt;
    logic [NUM_CH-1:0]     w_read_en_nxt;
    logic [DATA_WIDTH-1:0] w_out_data_nxt;
    logic [CH_W-1:0]       w_out_channel_nxt;
    logic                  w_out_valid_nxt;

    logic                  w_any_req;
    logic [CH_W-1:0]       w_pick;
    logic                  w_grant_empty;
    logic [DATA_WIDTH-1:0] w_grant_head;
    logic                  w_burst_more;
    logic                  w_continue;

`ifndef FIFO_DRAIN_ARB_PRIO_EN
    logic [CH_W-1:0]       r_last_grant;
    logic [CH_W-1:0]       w_last_grant_nxt;
    logic [CH_W-1:0]       w_pick_ahead;
    logic [CH_W-1:0]       w_pick_wrap;
    logic                  w_has_ahead;
`endif

    assign w_any_req = |(~fifo_empty);

    // Choose the channel for the next burst (only consumed in IDLE)
    always_comb begin
        w_pick = '0;
`ifdef FIFO_DRAIN_ARB_PRIO_EN
        // Lowest-index non-empty channel wins; descending scan lets it overwrite
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (!fifo_empty[j]) w_pick = CH_W'(j);
        end
`else
        // Lowest requester above last_grant, else lowest requester at/below it
        w_pick_ahead = '0;
        w_pick_wrap  = '0;
        w_has_ahead  = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (!fifo_empty[j]) begin
                if (CH_W'(j) > r_last_grant) begin
                    w_pick_ahead = CH_W'(j);
                    w_has_ahead  = 1'b1;
                end else begin
                    w_pick_wrap = CH_W'(j);
                end
            end
        end
        w_pick = w_has_ahead ? w_pick_ahead : w_pick_wrap;
`endif
    end

    // Empty flag and head word of the currently granted channel
    always_comb begin
        w_grant_empty = 1'b1;
        w_grant_head  = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (CH_W'(j) == r_grant) begin
                w_grant_empty = fifo_empty[j];
                w_grant_head  = fifo_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_burst_more = ({1'b0, r_burst_cnt} + 9'd1) < 9'(BURST_LEN);
    assign w_continue   = w_burst_more && enable && !w_grant_empty;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable && w_any_req) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_PULSE;
            S_PULSE:   w_state_nxt = S_SEND;
            S_SEND: begin
                if (out_ready) w_state_nxt = w_continue ? S_CAPTURE : S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        w_grant_nxt       = r_grant;
        w_burst_cnt_nxt   = r_burst_cnt;
        w_read_en_nxt     = '0;
        w_out_data_nxt    = r_out_data;
        w_out_channel_nxt = r_out_channel;
        w_out_valid_nxt   = r_out_valid;
`ifndef FIFO_DRAIN_ARB_PRIO_EN
        w_last_grant_nxt  = r_last_grant;
`endif
        case (r_state)
            S_IDLE: begin
                if (enable && w_any_req) begin
                    w_grant_nxt     = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            S_CAPTURE: begin
                w_out_data_nxt    = w_grant_head;
                w_out_channel_nxt = r_grant;
                for (int j = 0; j < NUM_CH; j++) begin
                    w_read_en_nxt[j] = (CH_W'(j) == r_grant);
                end
            end
            S_PULSE: begin
                w_out_valid_nxt = 1'b1;
            end
            S_SEND: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_burst_cnt_nxt = r_burst_cnt + 8'd1;
`ifndef FIFO_DRAIN_ARB_PRIO_EN
                    if (!w_continue) w_last_grant_nxt = r_grant;
`endif
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers; reset drops any unaccepted word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_grant       <= '0;
            r_burst_cnt   <= '0;
            r_read_en     <= '0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_out_valid   <= 1'b0;
        end else begin
            r_grant       <= w_grant_nxt;
            r_burst_cnt   <= w_burst_cnt_nxt;
            r_read_en     <= w_read_en_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_channel <= w_out_channel_nxt;
            r_out_valid   <= w_out_valid_nxt;
        end
    end

`ifndef FIFO_DRAIN_ARB_PRIO_EN
    // Round-robin pointer; resets to the last channel so channel 0 wins first
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_last_grant <= CH_W'(NUM_CH - 1);
        else          r_last_grant <= w_last_grant_nxt;
    end
`endif

    assign fifo_read_en = r_read_en;
    assign out_data     = r_out_data;
    assign out_channel  = r_out_channel;
    assign out_valid    = r_out_valid;
    assign busy         = (r_state != S_IDLE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter (3 channels, 8-bit words, burst length 4).
// Bench FIFOs pop on a rising edge of fifo_read_en. A transaction-level model
// predicts the accepted (channel, word) sequence from the queued contents.
module tb_fifo_drain_arbiter;
  localparam int DW  = 8;
  localparam int NCH = 3;
  localparam int BL  = 4;
  localparam int CW  = 2;
  localparam int W   = CW + DW;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic out_ready = 1'b0;
  logic [NCH-1:0] fifo_empty = '1;
  logic [NCH*DW-1:0] fifo_data = '0;
  logic [NCH-1:0] fifo_read_en;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_channel;
  logic out_valid;
  logic busy;
  logic [1:0] dbg_state;

  fifo_drain_arbiter #(.DATA_WIDTH(DW), .NUM_CH(NCH), .BURST_LEN(BL)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
    .out_data(out_data), .out_channel(out_channel), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int low_cnt = 1;
  int pulse_cnt = 0;
  int m_last = NCH - 1;
  int ready_mode = 1;
  logic [W-1:0] exp_q[$];
  int pulse_cyc[$];
  logic [DW-1:0] fmem[NCH][256];
  int fhead[NCH];
  int ftail[NCH];
  logic [NCH-1:0] prev_ren = '0;
  bit was_acc = 0;
  bit was_hold = 0;
  bit drop_en = 0;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_ch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_fifo();
    for (int k = 0; k < NCH; k++) begin
      fifo_empty[k] = (fhead[k] == ftail[k]);
      fifo_data[k*DW +: DW] = (fhead[k] < ftail[k]) ? fmem[k][fhead[k]] : '0;
    end
  endtask

  task automatic load(input int ch, input int n, input logic [DW-1:0] base, input bit rnd);
    if (fhead[ch] == ftail[ch]) begin
      fhead[ch] = 0;
      ftail[ch] = 0;
    end
    for (int i = 0; i < n; i++) begin
      if (ftail[ch] < 256) begin
        fmem[ch][ftail[ch]] = rnd ? DW'($urandom) : base + DW'(i);
        ftail[ch]++;
      end
    end
    drive_fifo();
  endtask

  // Reference model: drain queued words burst by burst from the rules
  task automatic model_plan();
    int h[NCH];
    int g;
    int n;
    bit any;
    for (int k = 0; k < NCH; k++) h[k] = fhead[k];
    any = 1;
    while (any) begin
      any = 0;
      for (int k = 0; k < NCH; k++) if (h[k] < ftail[k]) any = 1;
      if (any) begin
        g = 0;
`ifdef FIFO_DRAIN_ARB_PRIO_EN
        for (int k = NCH - 1; k >= 0; k--) if (h[k] < ftail[k]) g = k;
`else
        for (int i = NCH; i >= 1; i--) if (h[(m_last + i) % NCH] < ftail[(m_last + i) % NCH]) g = (m_last + i) % NCH;
`endif
        n = 0;
        while (n < BL && h[g] < ftail[g]) begin
          exp_q.push_back({CW'(g), fmem[g][h[g]]});
          h[g]++;
          n++;
        end
        m_last = g;
      end
    end
  endtask

  task automatic clear_tb_state();
    exp_q.delete();
    was_acc = 0;
    was_hold = 0;
    drop_en = 0;
    prev_ren = '0;
    low_cnt = 1;
    m_last = NCH - 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b0;
    ready_mode = 1;
    for (int k = 0; k < NCH; k++) begin
      fhead[k] = 0;
      ftail[k] = 0;
    end
    drive_fifo();
    clear_tb_state();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    enable = 1'b1;
  endtask

  // One cycle: compare process, FIFO pops, then drive inputs for next edge
  task automatic step();
    @(negedge clock);
    cyc++;
    check("read_en_onehot", $countones(fifo_read_en) <= 1, 1);
    if (fifo_read_en != '0) begin
      check("read_en_gap", low_cnt >= 2, 1);
      low_cnt = 0;
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
    end else begin
      low_cnt++;
    end
    if (was_acc) check("valid_drops_after_accept", out_valid, 0);
    if (was_hold) check("hold_stable", {out_valid, out_channel, out_data}, {1'b1, hold_ch, hold_data});
    for (int k = 0; k < NCH; k++) begin
      if (fifo_read_en[k] && !prev_ren[k]) begin
        check("pop_nonempty", fhead[k] < ftail[k], 1);
        if (fhead[k] < ftail[k]) fhead[k]++;
      end
    end
    prev_ren = fifo_read_en;
    drive_fifo();
    if (drop_en && fifo_read_en != '0) begin
      enable = 1'b0;
      drop_en = 0;
    end
    case (ready_mode)
      0: out_ready = ($urandom_range(0, 3) != 0);
      1: out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
    was_acc = out_valid && out_ready;
    was_hold = out_valid && !out_ready;
    hold_data = out_data;
    hold_ch = out_channel;
    if (was_acc) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL accept_unexpected: actual ch%0d/%0h required no word", out_channel, out_data);
      end else begin
        check("accept_word", {out_channel, out_data}, exp_q.pop_front());
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((exp_q.size() != 0 || busy) && c < budget) begin
      step();
      c++;
    end
    check(name, (exp_q.size() == 0) && !busy, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c = 0;
    while (!out_valid && c < budget) begin
      step();
      c++;
    end
    check(name, out_valid, 1);
  endtask

  initial begin
    logic [W-1:0] t1[3];
    int ord2[12];
    int p0;

    // reset state
    do_reset();
    check("rst_read_en", fifo_read_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_channel", out_channel, 0);
    check("rst_busy", busy, 0);

    // single channel, three words, sink always ready
    t1 = '{10'h011, 10'h022, 10'h033};
    ready_mode = 1;
    fmem[0][0] = 8'h11; fmem[0][1] = 8'h22; fmem[0][2] = 8'h33;
    ftail[0] = 3;
    drive_fifo();
    model_plan();
    check("t1_plan_size", exp_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_plan_word", exp_q[i], t1[i]);
    pulse_cyc.delete();
    drain("t1_drain", 200);
    check("t1_pulses", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      check("t1_spacing_a", pulse_cyc[1] - pulse_cyc[0], 3);
      check("t1_spacing_b", pulse_cyc[2] - pulse_cyc[1], 3);
    end
    check("t1_busy_idle", busy, 0);

    // two channels x 6 words, bursts of 4
    do_reset();
`ifdef FIFO_DRAIN_ARB_PRIO_EN
    ord2 = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
`else
    ord2 = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
`endif
    load(0, 6, 8'hA0, 0);
    load(1, 6, 8'hB0, 0);
    model_plan();
    check("t2_plan_size", exp_q.size(), 12);
    for (int i = 0; i < 12; i++) check("t2_plan_order", exp_q[i][DW +: CW], ord2[i]);
    ready_mode = 0;
    drain("t2_drain", 3000);

    // sink stalls for 10 cycles with a word pending
    ready_mode = 2;
    load(1, 2, 8'hC0, 0);
    model_plan();
    wait_valid("t3_valid", 20);
    p0 = pulse_cnt;
    repeat (10) step();
    check("t3_no_pulse_in_stall", pulse_cnt - p0, 0);
    check("t3_still_valid", out_valid, 1);
    ready_mode = 1;
    drain("t3_drain", 200);

    // enable dropped during the pulse: one word only, then idle
    ready_mode = 1;
    load(0, 5, 8'h50, 0);
    exp_q.push_back({2'd0, 8'h50});
    p0 = pulse_cnt;
    drop_en = 1;
    repeat (20) step();
    check("t4_one_word", exp_q.size(), 0);
    check("t4_one_pulse", pulse_cnt - p0, 1);
    check("t4_idle", busy, 0);
    enable = 1'b1;
    m_last = 0;
    model_plan();
    check("t4_rest_size", exp_q.size(), 4);
    drain("t4_drain", 300);

    // async reset while a ch1 word waits in SEND; ch0 must win afterwards
    ready_mode = 2;
    load(1, 3, 8'h61, 0);
    wait_valid("t5_valid", 20);
    load(0, 3, 8'h71, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t5_valid_cleared", out_valid, 0);
    check("t5_read_en_cleared", fifo_read_en, 0);
    check("t5_busy_cleared", busy, 0);
    check("t5_data_cleared", out_data, 0);
    clear_tb_state();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_plan();
    check("t5_plan_size", exp_q.size(), 5);
    check("t5_plan_first", exp_q[0], {2'd0, 8'h71});
    ready_mode = 1;
    drain("t5_drain", 300);

`ifdef FIFO_DRAIN_ARB_PRIO_EN
    // fixed priority: ch0 (8 words) drains fully before ch1 (2 words)
    do_reset();
    load(0, 8, 8'h80, 0);
    load(1, 2, 8'h90, 0);
    model_plan();
    check("prio_plan_size", exp_q.size(), 10);
    for (int i = 0; i < 10; i++) check("prio_plan_order", exp_q[i][DW +: CW], (i < 8) ? 0 : 1);
    ready_mode = 0;
    drain("prio_drain", 2000);
`endif

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < NCH; k++) load(k, $urandom_range(0, 9), 8'h00, 1);
      model_plan();
      ready_mode = 0;
      if (exp_q.size() > 0) drain("rand_drain", 3000);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (5) step();
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Round-robin arbiter that drains NUM_CH edge-triggered FIFOs into one shared downstream sink, such as a UART TX or LED/debug sink, over a valid/ready handshake.
- Generates the read strobes the FIFOs need. Each pop is a single-cycle rising-edge pulse, followed by a mandatory low gap.
- Holds each popped word until the sink accepts it.
- Sits between the per-source FIFOs and the single consumer.

Parameters:
- DATA_WIDTH, 8: width of each FIFO word and of out_data.
- NUM_CH, 2: number of requesting FIFOs. Legal range 2..8.
- BURST_LEN, 4: maximum words drained from the granted channel before the grant rotates. Legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new grant is issued; a word already in flight completes.
- fifo_empty  in  NUM_CH  per-channel FIFO empty flag.
- fifo_data  in  NUM_CH*DATA_WIDTH  per-channel FIFO head word. Channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- fifo_read_en  out  NUM_CH  per-channel pop strobe. Registered; the FIFO pops on its rising edge.
- out_data  out  DATA_WIDTH  word presented to the sink. Registered.
- out_channel  out  max(1,$clog2(NUM_CH))  source channel of out_data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the word when out_valid && out_ready at a clock edge.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE.
  - fifo_read_en=0, out_valid=0, out_data=0, out_channel=0, busy=0.
  - last_grant = NUM_CH-1, so channel 0 wins first.
  - burst_cnt = 0.
- A reset asserted mid-operation drops any popped-but-unaccepted word. This is the required behaviour.
- State machine, all outputs registered:
  - IDLE:
    - If enable and any fifo_empty bit is 0, select grant g = first non-empty channel searching last_grant+1, last_grant+2, ... modulo NUM_CH.
    - burst_cnt <= 0; go to CAPTURE.
    - Otherwise stay in IDLE.
  - CAPTURE:
    - out_data <= fifo_data slice g; out_channel <= g.
    - fifo_read_en[g] <= 1; go to PULSE.
  - PULSE:
    - fifo_read_en[g] <= 0; out_valid <= 1; go to SEND.
    - fifo_read_en is therefore high for exactly 1 cycle.
  - SEND:
    - Hold out_data and out_valid until out_ready.
    - On acceptance: out_valid <= 0; burst_cnt <= burst_cnt+1.
    - If burst_cnt+1 < BURST_LEN and enable and !fifo_empty[g], go to CAPTURE with the same g.
    - Otherwise last_grant <= g and go to IDLE.
- Timing:
  - Grant to out_valid: 2 cycles (CAPTURE, PULSE).
  - Peak throughput: 1 word per 3 cycles, with out_ready tied high.
  - fifo_read_en stays low for at least 2 cycles between pulses, which satisfies the FIFO edge detector.
  - The FIFO empty flag and head word have settled by the time they are sampled in SEND.
- After reset, fifo_read_en is low for at least one cycle before any pulse. This guarantees the first edge is detected even though the FIFO's edge register resets high.
- At most one fifo_read_en bit is high in any cycle. Non-granted bits are always 0.
- fifo_empty and fifo_data of channel g are sampled only in IDLE, CAPTURE and SEND. Changes on non-granted channels during a burst do not affect the burst.
- enable falling during PULSE or SEND: the current word is still delivered, then the block returns to IDLE.
- A channel that goes empty mid-burst ends the burst early and the grant rotates.
- A single requesting channel is re-granted repeatedly: burst, IDLE, burst, and so on.
- out_data and out_channel are stable whenever out_valid=1.

Optional Feature:
- Macro: FIFO_DRAIN_ARB_PRIO_EN.
- Defined: fixed priority replaces round-robin. The lowest-index non-empty channel always wins in IDLE; last_grant is unused. BURST_LEN still bounds each burst, so a higher-priority channel pre-empts at burst boundaries.
- Undefined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset, then ch0 holds 3 words (0x11,0x22,0x33), ch1 empty, out_ready=1: three one-cycle pulses on fifo_read_en[0], each separated by 2 low cycles; out_data sequence 0x11,0x22,0x33 with out_channel=0; busy returns to 0.
- ch0 and ch1 each hold 6 words, BURST_LEN=4: order is ch0×4, ch1×4, ch0×2, ch1×2; no cycle has both read_en bits high.
- out_ready held low for 10 cycles while out_valid=1: out_data and out_channel are held constant; no further fifo_read_en pulse; word accepted on the cycle out_ready rises.
- enable dropped during PULSE with ch0 holding 5 words: exactly 1 word delivered; block goes to IDLE; no further pulses until enable=1.
- reset_n pulsed low while in SEND: out_valid, fifo_read_en and busy go to 0 immediately (async); after release, channel 0 is granted first.
- With FIFO_DRAIN_ARB_PRIO_EN defined, ch0 holds 8 words and ch1 holds 2 words: ch0×4, ch0×4, then ch1×2.
